// File: rtl/stack_ctrl.sv
// Stack pointer / occupancy controller for one J1 stack register file.
// Turns per-instruction stack deltas into register-file port signals and keeps sticky error flags.
module stack_ctrl #(
    parameter int size  = 32,
    parameter int width = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [1:0]       delta,
    input  logic [width-1:0] d,
    input  logic             clr_err,
    input  logic [width-1:0] rf_q,
    output logic             rf_wen,
    output logic [4:0]       rf_wa,
    output logic [4:0]       rf_ra,
    output logic [width-1:0] rf_d,
    output logic [width-1:0] nos,
    output logic [5:0]       depth,
    output logic             empty,
    output logic             full,
    output logic             overflow,
    output logic             underflow
);
    localparam logic [4:0] SP_LAST   = 5'(size - 1);
    localparam logic [4:0] SP_LAST2  = 5'(size - 2);
    localparam logic [5:0] DEPTH_MAX = 6'(size);

    logic [4:0] sp_q, sp_d, sp_n, sp_m1, sp_m2;
    logic [5:0] depth_q, depth_d, pop_k;
    logic       overflow_q, overflow_d, underflow_q, underflow_d;
    logic       push, pop;

    always_comb begin
        push  = en && (delta == 2'b01);
        pop   = en && delta[1];
        pop_k = (delta == 2'b10) ? 6'd2 : 6'd1;

        // Explicit modulo-size wrap so non-power-of-two depths work.
        sp_n  = (sp_q == SP_LAST) ? 5'd0 : sp_q + 5'd1;
        sp_m1 = (sp_q == 5'd0) ? SP_LAST : sp_q - 5'd1;
        if (sp_q == 5'd0)
            sp_m2 = SP_LAST2;
        else if (sp_q == 5'd1)
            sp_m2 = SP_LAST;
        else
            sp_m2 = sp_q - 5'd2;

        sp_d        = sp_q;
        depth_d     = depth_q;
        overflow_d  = clr_err ? 1'b0 : overflow_q;
        underflow_d = clr_err ? 1'b0 : underflow_q;

        if (push) begin
            sp_d = sp_n;
            if (depth_q == DEPTH_MAX)
                overflow_d = 1'b1;
            else
                depth_d = depth_q + 6'd1;
        end else if (pop) begin
            sp_d = (pop_k == 6'd2) ? sp_m2 : sp_m1;
            if (pop_k > depth_q) begin
                depth_d     = 6'd0;
                underflow_d = 1'b1;
            end else begin
                depth_d = depth_q - pop_k;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sp_q        <= 5'd0;
            depth_q     <= 6'd0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            sp_q        <= sp_d;
            depth_q     <= depth_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    assign rf_wen    = push && !reset;
    assign rf_wa     = sp_n;
    assign rf_d      = d;
    assign rf_ra     = sp_q;
    assign nos       = rf_q;
    assign depth     = depth_q;
    assign empty     = (depth_q == 6'd0);
    assign full      = (depth_q == DEPTH_MAX);
    assign overflow  = overflow_q;
    assign underflow = underflow_q;
endmodule

// File: tb/tb_stack_ctrl.sv
// Self-checking bench for stack_ctrl: a size-32 and a size-5 instance share one stimulus stream,
// each beside a behavioural register file (sync write, async read).
module tb_stack_ctrl;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        en = 1'b0;
    logic [1:0]  delta = 2'b00;
    logic [15:0] d = 16'h0;
    logic        clr_err = 1'b0;

    logic        wen_a, wen_b;
    logic [4:0]  wa_a, wa_b, ra_a, ra_b;
    logic [15:0] rfd_a, rfd_b, q_a, q_b, nos_a, nos_b;
    logic [5:0]  depth_a, depth_b;
    logic        empty_a, empty_b, full_a, full_b;
    logic        ovf_a, ovf_b, unf_a, unf_b;

    logic [15:0] mem_a [32];
    logic [15:0] mem_b [32];

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (wen_a) mem_a[wa_a] <= rfd_a;
        if (wen_b) mem_b[wa_b] <= rfd_b;
    end
    assign q_a = mem_a[ra_a];
    assign q_b = mem_b[ra_b];

    stack_ctrl #(.size(32), .width(16)) dut_a (
        .clk(clk), .reset(reset), .en(en), .delta(delta), .d(d), .clr_err(clr_err),
        .rf_q(q_a), .rf_wen(wen_a), .rf_wa(wa_a), .rf_ra(ra_a), .rf_d(rfd_a),
        .nos(nos_a), .depth(depth_a), .empty(empty_a), .full(full_a),
        .overflow(ovf_a), .underflow(unf_a)
    );

    stack_ctrl #(.size(5), .width(16)) dut_b (
        .clk(clk), .reset(reset), .en(en), .delta(delta), .d(d), .clr_err(clr_err),
        .rf_q(q_b), .rf_wen(wen_b), .rf_wa(wa_b), .rf_ra(ra_b), .rf_d(rfd_b),
        .nos(nos_b), .depth(depth_b), .empty(empty_b), .full(full_b),
        .overflow(ovf_b), .underflow(unf_b)
    );

    typedef struct {
        logic        rst;
        logic        en;
        logic [1:0]  delta;
        logic [15:0] d;
        logic        clr;
        logic [5:0]  depth;
        logic        emp;
        logic        full;
        logic        ovf;
        logic        unf;
        logic [4:0]  sp;
        logic        chk_nos;
        logic [15:0] nos;
    } vec_t;

    typedef struct {
        vec_t v;
        logic sel;
        int   idx;
    } exp_t;

    exp_t sb[$];
    vec_t tbl[16];
    int   n_vec = 0;
    int   n_bad = 0;
    int   n_txn = 0;

    localparam logic [1:0] PUSH = 2'b01;
    localparam logic [1:0] POP1 = 2'b11;
    localparam logic [1:0] POP2 = 2'b10;
    localparam logic [1:0] HOLD = 2'b00;

    function automatic vec_t mk(input logic rst, input logic e, input logic [1:0] dl,
                                input logic [15:0] dv, input logic clr, input logic [5:0] dep,
                                input logic emp, input logic fl, input logic ov, input logic un,
                                input logic [4:0] sp, input logic cn, input logic [15:0] nv);
        vec_t v;
        v.rst = rst; v.en = e; v.delta = dl; v.d = dv; v.clr = clr;
        v.depth = dep; v.emp = emp; v.full = fl; v.ovf = ov; v.unf = un;
        v.sp = sp; v.chk_nos = cn; v.nos = nv;
        return v;
    endfunction

    task automatic chk(input string name, input int idx, input int act, input int req);
        n_vec++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s txn %0d: got 0x%0h, expected 0x%0h", name, idx, act, req);
        end
    endtask

    // Drives one instruction, checks the combinational write port, then compares committed state.
    task automatic drive(input vec_t v, input logic sel);
        exp_t e;
        exp_t got;
        logic exp_wen;
        reset = v.rst; en = v.en; delta = v.delta; d = v.d; clr_err = v.clr;
        e.v = v; e.sel = sel; e.idx = n_txn;
        sb.push_back(e);
        #1;
        exp_wen = v.en && (v.delta == PUSH) && !v.rst;
        chk("rf_wen", n_txn, int'(sel ? wen_b : wen_a), int'(exp_wen));
        if (exp_wen) begin
            chk("rf_wa", n_txn, int'(sel ? wa_b : wa_a), int'(v.sp));
            chk("rf_d", n_txn, int'(sel ? rfd_b : rfd_a), int'(v.d));
        end
        @(posedge clk);
        #1;
        got = sb.pop_front();
        chk("depth", got.idx, int'(got.sel ? depth_b : depth_a), int'(got.v.depth));
        chk("empty", got.idx, int'(got.sel ? empty_b : empty_a), int'(got.v.emp));
        chk("full", got.idx, int'(got.sel ? full_b : full_a), int'(got.v.full));
        chk("overflow", got.idx, int'(got.sel ? ovf_b : ovf_a), int'(got.v.ovf));
        chk("underflow", got.idx, int'(got.sel ? unf_b : unf_a), int'(got.v.unf));
        chk("sp", got.idx, int'(got.sel ? ra_b : ra_a), int'(got.v.sp));
        if (got.v.chk_nos)
            chk("nos", got.idx, int'(got.sel ? nos_b : nos_a), int'(got.v.nos));
        $display("txn %0d dut%s rst=%0b en=%0b delta=%b d=%h clr=%0b -> depth=%0d sp=%0d ovf=%0b unf=%0b",
                 got.idx, got.sel ? "B" : "A", v.rst, v.en, v.delta, v.d, v.clr,
                 got.sel ? depth_b : depth_a, got.sel ? ra_b : ra_a,
                 got.sel ? ovf_b : ovf_a, got.sel ? unf_b : unf_a);
        n_txn++;
    endtask

    initial begin
        vec_t v;
        tbl[0]  = mk(1'b1, 1'b0, HOLD, 16'h0000, 1'b0, 6'd0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0,  1'b0, 16'h0000);
        tbl[1]  = mk(1'b0, 1'b1, PUSH, 16'h1111, 1'b0, 6'd1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd1,  1'b1, 16'h1111);
        tbl[2]  = mk(1'b0, 1'b1, PUSH, 16'h2222, 1'b0, 6'd2, 1'b0, 1'b0, 1'b0, 1'b0, 5'd2,  1'b1, 16'h2222);
        tbl[3]  = mk(1'b0, 1'b1, PUSH, 16'h3333, 1'b0, 6'd3, 1'b0, 1'b0, 1'b0, 1'b0, 5'd3,  1'b1, 16'h3333);
        tbl[4]  = mk(1'b0, 1'b1, POP1, 16'h0000, 1'b0, 6'd2, 1'b0, 1'b0, 1'b0, 1'b0, 5'd2,  1'b1, 16'h2222);
        tbl[5]  = mk(1'b0, 1'b1, POP2, 16'h0000, 1'b0, 6'd0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0,  1'b0, 16'h0000);
        tbl[6]  = mk(1'b0, 1'b0, PUSH, 16'hDEAD, 1'b0, 6'd0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0,  1'b0, 16'h0000);
        tbl[7]  = mk(1'b0, 1'b1, HOLD, 16'hDEAD, 1'b0, 6'd0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0,  1'b0, 16'h0000);
        tbl[8]  = mk(1'b0, 1'b1, PUSH, 16'h00AA, 1'b0, 6'd1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd1,  1'b1, 16'h00AA);
        tbl[9]  = mk(1'b0, 1'b1, POP2, 16'h0000, 1'b0, 6'd0, 1'b1, 1'b0, 1'b0, 1'b1, 5'd31, 1'b0, 16'h0000);
        tbl[10] = mk(1'b0, 1'b0, HOLD, 16'h0000, 1'b1, 6'd0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd31, 1'b0, 16'h0000);
        tbl[11] = mk(1'b0, 1'b1, POP1, 16'h0000, 1'b1, 6'd0, 1'b1, 1'b0, 1'b0, 1'b1, 5'd30, 1'b0, 16'h0000);
        tbl[12] = mk(1'b0, 1'b0, HOLD, 16'h0000, 1'b1, 6'd0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd30, 1'b0, 16'h0000);
        tbl[13] = mk(1'b0, 1'b1, POP1, 16'h0000, 1'b0, 6'd0, 1'b1, 1'b0, 1'b0, 1'b1, 5'd29, 1'b0, 16'h0000);
        tbl[14] = mk(1'b1, 1'b1, PUSH, 16'h7777, 1'b1, 6'd0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0,  1'b0, 16'h0000);
        tbl[15] = mk(1'b0, 1'b1, PUSH, 16'h4444, 1'b0, 6'd1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd1,  1'b1, 16'h4444);

        @(posedge clk);
        #1;
        for (int i = 0; i < 16; i++) drive(tbl[i], 1'b0);

        // Fill the 32-deep stack, then overflow it.
        drive(mk(1'b1, 1'b0, HOLD, 16'h0, 1'b0, 6'd0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 16'h0), 1'b0);
        for (int i = 0; i < 32; i++) begin
            v = mk(1'b0, 1'b1, PUSH, 16'(16'h0100 + i), 1'b0, 6'(i + 1), 1'b0, (i == 31), 1'b0, 1'b0,
                   5'((i + 1) % 32), 1'b1, 16'(16'h0100 + i));
            drive(v, 1'b0);
        end
        drive(mk(1'b0, 1'b1, PUSH, 16'hBEEF, 1'b0, 6'd32, 1'b0, 1'b1, 1'b1, 1'b0, 5'd1, 1'b1, 16'hBEEF), 1'b0);
        drive(mk(1'b0, 1'b1, POP1, 16'h0, 1'b0, 6'd31, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 1'b1, 16'h011F), 1'b0);
        drive(mk(1'b0, 1'b0, HOLD, 16'h0, 1'b1, 6'd31, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 16'h011F), 1'b0);

        // Hold: en low with a push request must not write or move anything.
        drive(mk(1'b1, 1'b0, HOLD, 16'h0, 1'b0, 6'd0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 16'h0), 1'b0);
        drive(mk(1'b0, 1'b1, PUSH, 16'hA001, 1'b0, 6'd1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd1, 1'b1, 16'hA001), 1'b0);
        drive(mk(1'b0, 1'b1, PUSH, 16'hA002, 1'b0, 6'd2, 1'b0, 1'b0, 1'b0, 1'b0, 5'd2, 1'b1, 16'hA002), 1'b0);
        for (int i = 0; i < 10; i++)
            drive(mk(1'b0, 1'b0, PUSH, 16'(16'hC000 + i), 1'b0, 6'd2, 1'b0, 1'b0, 1'b0, 1'b0, 5'd2, 1'b1, 16'hA002), 1'b0);
        drive(mk(1'b0, 1'b1, HOLD, 16'hC0DE, 1'b0, 6'd2, 1'b0, 1'b0, 1'b0, 1'b0, 5'd2, 1'b1, 16'hA002), 1'b0);

        // Size-5 instance: wrap, overflow, and the 0-2 / 1-2 pop wraps.
        drive(mk(1'b1, 1'b0, HOLD, 16'h0, 1'b0, 6'd0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 16'h0), 1'b1);
        for (int i = 1; i <= 6; i++) begin
            v = mk(1'b0, 1'b1, PUSH, 16'(i), 1'b0, 6'((i > 5) ? 5 : i), 1'b0, (i >= 5), (i == 6), 1'b0,
                   5'(i % 5), 1'b1, 16'(i));
            drive(v, 1'b1);
        end
        drive(mk(1'b0, 1'b1, POP2, 16'h0, 1'b0, 6'd3, 1'b0, 1'b0, 1'b1, 1'b0, 5'd4, 1'b1, 16'd4), 1'b1);
        drive(mk(1'b0, 1'b1, POP1, 16'h0, 1'b1, 6'd2, 1'b0, 1'b0, 1'b0, 1'b0, 5'd3, 1'b1, 16'd3), 1'b1);
        drive(mk(1'b0, 1'b1, POP2, 16'h0, 1'b0, 6'd0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd1, 1'b1, 16'd6), 1'b1);
        drive(mk(1'b0, 1'b1, POP1, 16'h0, 1'b0, 6'd0, 1'b1, 1'b0, 1'b0, 1'b1, 5'd0, 1'b0, 16'h0), 1'b1);
        drive(mk(1'b0, 1'b1, POP2, 16'h0, 1'b0, 6'd0, 1'b1, 1'b0, 1'b0, 1'b1, 5'd3, 1'b1, 16'd3), 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
